epass_checker: RTL and testbench

- Toll-side E-pass responder. It produces the `valid_Epass` verdict and the `enable` release that the lane controller consumes.
- On a check request it receives the vehicle tag ID serially from the RFID front end and looks up a local account table.
- If the account qualifies, it deducts the toll and answers accept (2'b10). Otherwise it answers reject (2'b01), holds that verdict until manual cash payment, then pulses `enable`.

---
 rtl/epass_checker_pkg.sv | 31 +++
 rtl/epass_checker_if.sv | 32 +++
 rtl/epass_account_table.sv | 62 ++++++
 rtl/epass_checker.sv | 114 +++++++++++
 tb/tb_epass_checker.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/epass_checker_pkg.sv
// Shared definitions for the E-pass checker: verdict codes, FSM states, defaults.
package epass_checker_pkg;

  localparam int unsigned ID_W_DEF     = 8;
  localparam int unsigned NUM_ACCT_DEF = 16;
  localparam int unsigned BAL_W_DEF    = 16;
  localparam int unsigned FEE_DEF      = 30;
  localparam int unsigned TIMEOUT_DEF  = 255;

  localparam logic [1:0] EPASS_NONE = 2'b00;
  localparam logic [1:0] EPASS_OK   = 2'b10;
  localparam logic [1:0] EPASS_BAD  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_LOOKUP,
    ST_ACCEPT,
    ST_REJECT,
    ST_RELEASE
  } state_t;

  function automatic logic [1:0] verdict_of(state_t s);
    case (s)
      ST_ACCEPT:             verdict_of = EPASS_OK;
      ST_REJECT, ST_RELEASE: verdict_of = EPASS_BAD;
      default:               verdict_of = EPASS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/epass_checker_if.sv
// Lane-side bundle of the E-pass checker: request/tag/top-up/cash inputs and verdict outputs.
interface epass_checker_if
  import epass_checker_pkg::*;
#(
  parameter int unsigned NUM_ACCT = NUM_ACCT_DEF,
  parameter int unsigned BAL_W    = BAL_W_DEF
);
  localparam int unsigned IDX_W = $clog2(NUM_ACCT);

  logic             req;
  logic             tag_valid;
  logic             tag_bit;
  logic             topup_valid;
  logic [IDX_W-1:0] topup_idx;
  logic [BAL_W-1:0] topup_amount;
  logic             cash_paid;
  logic [1:0]       valid_Epass;
  logic             enable;
  logic             busy;
  logic [BAL_W-1:0] last_balance;

  modport master (
    output req, tag_valid, tag_bit, topup_valid, topup_idx, topup_amount, cash_paid,
    input  valid_Epass, enable, busy, last_balance
  );

  modport slave (
    input  req, tag_valid, tag_bit, topup_valid, topup_idx, topup_amount, cash_paid,
    output valid_Epass, enable, busy, last_balance
  );

endinterface

// File: rtl/epass_account_table.sv
// Account balance table: one combinational read, one deduct and one top-up port merged per account.
module epass_account_table
  import epass_checker_pkg::*;
#(
  parameter int unsigned NUM_ACCT = NUM_ACCT_DEF,
  parameter int unsigned BAL_W    = BAL_W_DEF,
  parameter int unsigned FEE      = FEE_DEF,
  localparam int unsigned IDX_W   = $clog2(NUM_ACCT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [BAL_W-1:0] rd_bal,
  output logic             rd_reg,
  input  logic             ded_valid,
  input  logic [IDX_W-1:0] ded_idx,
  input  logic             topup_valid,
  input  logic [IDX_W-1:0] topup_idx,
  input  logic [BAL_W-1:0] topup_amount
);

  logic [BAL_W-1:0] bal      [NUM_ACCT];
  logic [BAL_W-1:0] bal_next [NUM_ACCT];
  logic [BAL_W:0]   sum      [NUM_ACCT];
  logic [NUM_ACCT-1:0] registered;
  logic [NUM_ACCT-1:0] ded_hit;
  logic [NUM_ACCT-1:0] top_hit;

  always_comb begin
    rd_bal = '0;
    rd_reg = 1'b0;
    if (32'(rd_idx) < NUM_ACCT) begin
      rd_bal = bal[rd_idx];
      rd_reg = registered[rd_idx];
    end
  end

  // Deduction is only issued when bal >= FEE, so subtracting first cannot wrap.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ACCT; i++) begin
      ded_hit[i]  = ded_valid && (32'(ded_idx) == i);
      top_hit[i]  = topup_valid && (32'(topup_idx) == i);
      sum[i]      = {1'b0, bal[i]};
      if (ded_hit[i]) sum[i] = sum[i] - (BAL_W+1)'(FEE);
      if (top_hit[i]) sum[i] = sum[i] + {1'b0, topup_amount};
      bal_next[i] = sum[i][BAL_W] ? '1 : sum[i][BAL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ACCT; i++) bal[i] <= '0;
      registered <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ACCT; i++) begin
        if (ded_hit[i] || top_hit[i]) bal[i] <= bal_next[i];
        if (top_hit[i]) registered[i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/epass_checker.sv
// E-pass responder: serial tag receiver, timeout counter and verdict FSM over the account table.
module epass_checker
  import epass_checker_pkg::*;
#(
  parameter int unsigned ID_W     = ID_W_DEF,
  parameter int unsigned NUM_ACCT = NUM_ACCT_DEF,
  parameter int unsigned BAL_W    = BAL_W_DEF,
  parameter int unsigned FEE      = FEE_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input logic           clk,
  input logic           reset,
  epass_checker_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_ACCT);
  localparam int unsigned CNT_W = $clog2(ID_W + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  state_t           state, state_next;
  logic [ID_W-1:0]  id;
  logic [CNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [BAL_W-1:0] rd_bal;
  logic             rd_reg;
  logic             id_ok, qualifies, ded_valid;
  logic             frame_done, timed_out;
  logic [1:0]       verdict_next;
  logic             enable_next, busy_next;

  assign id_ok      = 32'(id) < NUM_ACCT;
  assign qualifies  = id_ok && rd_reg && (rd_bal >= BAL_W'(FEE));
  assign ded_valid  = (state == ST_LOOKUP) && qualifies;
  assign frame_done = (state == ST_RECV) && bus.tag_valid && (bit_cnt == CNT_W'(ID_W - 1));
  assign timed_out  = to_cnt == TO_W'(TIMEOUT - 1);

  epass_account_table #(
    .NUM_ACCT (NUM_ACCT),
    .BAL_W    (BAL_W),
    .FEE      (FEE)
  ) u_table (
    .clk          (clk),
    .reset        (reset),
    .rd_idx       (id[IDX_W-1:0]),
    .rd_bal       (rd_bal),
    .rd_reg       (rd_reg),
    .ded_valid    (ded_valid),
    .ded_idx      (id[IDX_W-1:0]),
    .topup_valid  (bus.topup_valid),
    .topup_idx    (bus.topup_idx),
    .topup_amount (bus.topup_amount)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (bus.req) state_next = ST_RECV;
      ST_RECV: begin
        if (frame_done)     state_next = ST_LOOKUP;
        else if (timed_out) state_next = ST_REJECT;
      end
      ST_LOOKUP:  state_next = qualifies ? ST_ACCEPT : ST_REJECT;
      ST_ACCEPT:  state_next = ST_IDLE;
      ST_REJECT:  if (bus.cash_paid) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    verdict_next = verdict_of(state_next);
    enable_next  = state_next == ST_RELEASE;
    busy_next    = state_next != ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      bus.valid_Epass <= EPASS_NONE;
      bus.enable      <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_next;
      bus.valid_Epass <= verdict_next;
      bus.enable      <= enable_next;
      bus.busy        <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id               <= '0;
      bit_cnt          <= '0;
      to_cnt           <= '0;
      bus.last_balance <= '0;
    end else begin
      if (state == ST_IDLE && bus.req) begin
        bit_cnt <= '0;
        to_cnt  <= '0;
      end
      if (state == ST_RECV) begin
        to_cnt <= to_cnt + 1'b1;
        if (bus.tag_valid) begin
          id      <= {id[ID_W-2:0], bus.tag_bit};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (state == ST_LOOKUP)
        bus.last_balance <= qualifies ? rd_bal - BAL_W'(FEE) : (id_ok ? rd_bal : '0);
    end
  end

endmodule

// File: tb/tb_epass_checker.sv
// Self-checking bench for epass_checker against an account-level reference model.
module tb_epass_checker;

  localparam int FEE = 30;
  localparam int SAT = 65535;
  localparam int NA  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  epass_checker_if #(.NUM_ACCT(16), .BAL_W(16)) bus ();

  epass_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_bal [NA];
  bit model_reg [NA];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < NA; i++) begin
      model_bal[i] = 0;
      model_reg[i] = 0;
    end
  endtask

  task automatic model_topup(input int idx, input int amt);
    model_bal[idx] = (model_bal[idx] + amt > SAT) ? SAT : model_bal[idx] + amt;
    model_reg[idx] = 1;
  endtask

  task automatic do_topup(input int idx, input int amt);
    bus.topup_valid  = 1'b1;
    bus.topup_idx    = 4'(idx);
    bus.topup_amount = 16'(amt);
    tick;
    bus.topup_valid  = 1'b0;
    model_topup(idx, amt);
  endtask

  task automatic check_outs(input string name, input logic [1:0] v, input logic en, input logic bz);
    n_checks++;
    if (bus.valid_Epass !== v || bus.enable !== en || bus.busy !== bz) begin
      n_fail++;
      $display("FAIL %s: got valid=%b enable=%b busy=%b expected valid=%b enable=%b busy=%b",
               name, bus.valid_Epass, bus.enable, bus.busy, v, en, bz);
    end
  endtask

  // Full transaction; optional top-up of the same account landing in the decision cycle.
  task automatic do_txn(input int id, input bit coll, input int coll_amt, input bit noise);
    bit accept;
    int exp_lb;
    int hold;
    accept = (id < NA) && model_reg[id] && (model_bal[id] >= FEE);
    if (accept) begin
      model_bal[id] = model_bal[id] - FEE;
      exp_lb = model_bal[id];
    end else begin
      exp_lb = (id < NA) ? model_bal[id] : 0;
    end
    if (coll) model_topup(id, coll_amt);

    bus.req = 1'b1;
    bus.tag_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.tag_bit = 1'($urandom_range(0, 1));
    tick;
    bus.req = 1'b0;
    for (int b = 7; b >= 0; b--) begin
      if (noise && $urandom_range(0, 3) == 0) begin
        bus.tag_valid = 1'b0;
        bus.tag_bit = 1'($urandom_range(0, 1));
        bus.req = 1'($urandom_range(0, 1));
        tick;
      end
      bus.tag_valid = 1'b1;
      bus.tag_bit = 1'((id >> b) & 1);
      bus.req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick;
    end
    bus.tag_valid = 1'b0;
    bus.req = 1'b0;
    check_outs("lookup_cycle", 2'b00, 1'b0, 1'b1);

    if (coll) begin
      bus.topup_valid  = 1'b1;
      bus.topup_idx    = 4'(id);
      bus.topup_amount = 16'(coll_amt);
    end
    tick;
    bus.topup_valid = 1'b0;
    check_outs(accept ? "verdict_accept" : "verdict_reject", accept ? 2'b10 : 2'b01, 1'b0, 1'b1);
    n_checks++;
    if (bus.last_balance !== 16'(exp_lb)) begin
      n_fail++;
      $display("FAIL last_balance id=%0d: got %0d expected %0d", id, bus.last_balance, exp_lb);
    end

    if (accept) begin
      tick;
      check_outs("after_accept", 2'b00, 1'b0, 1'b0);
    end else begin
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) begin
        tick;
        check_outs("reject_hold", 2'b01, 1'b0, 1'b1);
      end
      bus.cash_paid = 1'b1;
      tick;
      bus.cash_paid = 1'b0;
      check_outs("release", 2'b01, 1'b1, 1'b1);
      tick;
      check_outs("after_release", 2'b00, 1'b0, 1'b0);
    end
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    check_outs("reset_state", 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (bus.last_balance !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_last_balance: got %0d expected 0", bus.last_balance);
    end
    reset = 1'b0;
    model_clear();
    tick;
    check_outs("idle_after_reset", 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_accept;
    do_topup(5, 100);
    do_txn(5, 0, 0, 0);
  endtask

  task automatic test_exact_fee;
    apply_reset();
    do_topup(5, 30);
    do_txn(5, 0, 0, 0);
    do_txn(5, 0, 0, 0);
  endtask

  task automatic test_unknown;
    do_topup(4, 50);
    do_txn(8'h20, 0, 0, 0);
    do_txn(8'h24, 0, 0, 0);
    do_txn(8'h03, 0, 0, 0);
    do_txn(4, 0, 0, 0);
  endtask

  task automatic test_timeout;
    bus.req = 1'b1;
    tick;
    bus.req = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.tag_valid = 1'b1;
      bus.tag_bit = 1'(b & 1);
      tick;
    end
    bus.tag_valid = 1'b0;
    for (int k = 0; k < 251; k++) tick;
    check_outs("timeout_pending", 2'b00, 1'b0, 1'b1);
    tick;
    check_outs("timeout_reject", 2'b01, 1'b0, 1'b1);
    tick;
    check_outs("timeout_hold", 2'b01, 1'b0, 1'b1);
    bus.cash_paid = 1'b1;
    tick;
    bus.cash_paid = 1'b0;
    check_outs("timeout_release", 2'b01, 1'b1, 1'b1);
    tick;
    check_outs("timeout_idle", 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_collision;
    apply_reset();
    do_topup(7, 40);
    do_txn(7, 1, 50, 0);
    n_checks++;
    if (model_bal[7] != 60) begin
      n_fail++;
      $display("FAIL collision_model: got %0d expected 60", model_bal[7]);
    end
    do_txn(7, 0, 0, 0);
    do_txn(7, 0, 0, 0);
    do_txn(7, 0, 0, 0);
  endtask

  task automatic test_saturate;
    do_topup(9, 65000);
    do_topup(9, 65000);
    do_txn(9, 0, 0, 0);
  endtask

  task automatic test_reset_mid_recv;
    do_topup(2, 200);
    bus.req = 1'b1;
    tick;
    bus.req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.tag_valid = 1'b1;
      bus.tag_bit = 1'b0;
      tick;
    end
    bus.tag_valid = 1'b0;
    reset = 1'b1;
    tick;
    check_outs("mid_recv_reset", 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (bus.last_balance !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_recv_last_balance: got %0d expected 0", bus.last_balance);
    end
    reset = 1'b0;
    model_clear();
    do_txn(2, 0, 0, 0);
    do_txn(9, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        do_topup(int'($urandom_range(0, 15)), int'($urandom_range(0, 120)));
      do_txn(int'($urandom_range(0, 19)), 0, 0, 1);
    end
  endtask

  task automatic test_back_to_back;
    do_topup(1, 90);
    do_txn(1, 0, 0, 0);
    do_txn(1, 0, 0, 0);
    do_txn(1, 0, 0, 0);
    do_txn(1, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 1'b0;
    bus.tag_valid = 1'b0;
    bus.tag_bit = 1'b0;
    bus.topup_valid = 1'b0;
    bus.topup_idx = '0;
    bus.topup_amount = '0;
    bus.cash_paid = 1'b0;
    model_clear();

    test_reset();
    test_accept();
    test_exact_fee();
    test_unknown();
    test_timeout();
    test_collision();
    test_saturate();
    test_reset_mid_recv();
    test_back_to_back();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
